// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants, request FSM encoding and queue entry layouts.
package cpu_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam int          INSN_W       = 32;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] LINK_OFS     = 32'd8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } req_state_t;

   // Request waiting for its imem response; tag is the epoch it was issued in.
   typedef struct packed {
      logic [31:0] addr;
      logic        tag;
   } pend_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INSN_W-1:0] data;
   } obuf_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry visible combinationally, push accepted when full only alongside a pop.
// Flush empties the queue and overrides any push/pop in the same cycle.
module fetch_fifo #(
   parameter int W  = 32,
   parameter int D  = 2,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_dat,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [W-1:0]  o_head_dat,
   output logic [CW-1:0] o_count
);

   localparam int PW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]  r_mem [D];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_empty;
   logic          w_full;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CW'(D));
   assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
   assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= ptr_next(r_wr);
         if (w_do_pop)  r_rd <= ptr_next(r_rd);
         if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CW'(1);
         else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_rd];
   assign o_count    = r_cnt;

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: credit-limited in-order imem fetches, epoch-tagged so a redirect discards all younger work.
// Response reaches decode 1 cycle later; imem request held under backpressure, decode stall throttles via credits.
module if_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pcplus8,
   output logic        align_err
);

   localparam int CW = 3;

   req_state_t    r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_req_addr;
   logic          r_req_valid;
   logic          r_req_tag;
   logic          r_epoch;
   logic          r_align_err;
   logic [CW-1:0] r_credits;

   pend_t         w_pend_din;
   pend_t         w_pend_head;
   logic [CW-1:0] w_pend_cnt;
   obuf_t         w_obuf_din;
   obuf_t         w_obuf_head;
   logic [CW-1:0] w_obuf_cnt;

   logic          w_req_hs;
   logic          w_rsp;
   logic          w_rsp_keep;
   logic          w_rsp_drop;
   logic          w_pop;
   logic          w_can_issue;
   logic [CW-1:0] w_release;
   logic [CW-1:0] w_credits_mid;

   assign w_req_hs   = r_req_valid & imem_req_ready;
   assign w_rsp      = imem_rsp_valid & (w_pend_cnt != '0);
   // A response landing with a redirect belongs to the discarded path whatever its tag.
   assign w_rsp_keep = w_rsp & (w_pend_head.tag == r_epoch) & ~redirect;
   assign w_rsp_drop = w_rsp & ~w_rsp_keep;
   assign w_pop      = inst_valid & inst_ready;

   // Flush returns every buffered credit at once; a simultaneous pop is already inside that count.
   assign w_release     = redirect ? w_obuf_cnt : CW'(w_pop);
   assign w_credits_mid = r_credits - w_release - CW'(w_rsp_drop);
   assign w_can_issue   = ~redirect & (w_credits_mid < CW'(DEPTH))
                        & ((r_state == S_IDLE) | w_req_hs);

   assign w_pend_din = {r_req_addr, r_req_tag};
   assign w_obuf_din = {w_pend_head.addr, imem_rsp_data};

   fetch_fifo #(.W($bits(pend_t)), .D(DEPTH), .CW(CW)) u_pend (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_req_hs),
      .i_push_dat (w_pend_din),
      .i_pop      (w_rsp),
      .i_flush    (1'b0),
      .o_head_dat (w_pend_head),
      .o_count    (w_pend_cnt)
   );

   fetch_fifo #(.W($bits(obuf_t)), .D(DEPTH), .CW(CW)) u_obuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_rsp_keep),
      .i_push_dat (w_obuf_din),
      .i_pop      (w_pop),
      .i_flush    (redirect),
      .o_head_dat (w_obuf_head),
      .o_count    (w_obuf_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_req_addr  <= '0;
         r_req_valid <= 1'b0;
         r_req_tag   <= 1'b0;
         r_epoch     <= 1'b0;
         r_align_err <= 1'b0;
         r_credits   <= '0;
      end else begin
         r_align_err <= redirect & (|redirect_pc[1:0]);
         r_credits   <= w_credits_mid + CW'(w_can_issue);
         if (redirect) begin
            r_epoch <= ~r_epoch;
            r_pc    <= word_align(redirect_pc);
         end else if (w_can_issue) begin
            r_pc <= r_pc + PC_STEP;
         end
         case (r_state)
            S_IDLE: begin
               if (w_can_issue) begin
                  r_state     <= S_REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= r_pc;
                  r_req_tag   <= r_epoch;
               end
            end
            S_REQ: begin
               if (w_req_hs) begin
                  if (w_can_issue) begin
                     r_req_addr <= r_pc;
                     r_req_tag  <= r_epoch;
                  end else begin
                     r_state     <= S_IDLE;
                     r_req_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_req_addr;
   assign align_err      = r_align_err;
   assign inst_valid     = (w_obuf_cnt != '0);
   assign inst_data      = inst_valid ? w_obuf_head.data : '0;
   assign inst_pc        = inst_valid ? w_obuf_head.pc : '0;
   assign inst_pcplus8   = inst_valid ? (w_obuf_head.pc + LINK_OFS) : '0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: transaction-level fetch model plus hand-computed literal expectations.
module tb_if_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pcplus8;
   logic        align_err;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_3000), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pcplus8   (inst_pcplus8),
      .align_err      (align_err)
   );

   typedef struct {
      logic [31:0] addr;
      bit          fresh;
      bit          orphan;
      int          rdy;
   } ent_t;

   ent_t        imem_q[$];
   logic [31:0] m_deliver[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_p8[$];
   logic [31:0] m_next_addr;
   logic [31:0] m_stale_addr;
   bit          m_stale;
   bit          m_align;
   bit          m_after_rst;
   bit          prev_stall;
   bit          rsp_hold;
   int          cyc;
   int          errors;
   int          checks;
   int          n_hs;

   function automatic logic [31:0] iword(input logic [31:0] a);
      return {~a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare at negedge, advance the model for the coming edge, then drive imem response.
   task automatic tick();
      bit   hs;
      bit   pop;
      bit   take;
      int   live;
      ent_t e;
      ent_t n;
      @(negedge clk);
      hs   = imem_req_valid && imem_req_ready;
      pop  = inst_valid && inst_ready;
      take = 1'b0;
      chk("inst_valid", inst_valid, m_deliver.size() != 0);
      if (inst_valid && m_deliver.size() != 0) begin
         chk("inst_pc", inst_pc, m_deliver[0]);
         chk("inst_data", inst_data, iword(m_deliver[0]));
         chk("inst_pcplus8", inst_pcplus8, m_deliver[0] + 32'd8);
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, m_stale ? m_stale_addr : m_next_addr);
      chk("align_err", align_err, m_align);
      if (prev_stall)  chk("req_hold", imem_req_valid, 1);
      if (m_after_rst) chk("req_after_rst", imem_req_valid, 0);
      live = int'(imem_req_valid) + m_deliver.size();
      foreach (imem_q[i]) if (!imem_q[i].orphan) live++;
      checks++;
      if (live > DEPTH) begin
         errors++;
         $display("FAIL credits: %0d outstanding, limit %0d (cycle %0d)", live, DEPTH, cyc);
      end

      prev_stall = rst_n && imem_req_valid && !imem_req_ready;
      if (imem_rsp_valid && imem_q.size() != 0) begin
         e    = imem_q.pop_front();
         take = rst_n && !e.orphan && e.fresh && !redirect;
      end
      if (!rst_n) begin
         m_deliver.delete();
         m_next_addr = 32'h0000_3000;
         m_stale     = 1'b0;
         m_align     = 1'b0;
         m_after_rst = 1'b1;
         while (imem_q.size() > 1) void'(imem_q.pop_back());
         foreach (imem_q[i]) imem_q[i].orphan = 1'b1;
      end else begin
         m_after_rst = 1'b0;
         if (pop && m_deliver.size() != 0) begin
            void'(m_deliver.pop_front());
            if (!redirect) begin
               got_pc.push_back(inst_pc);
               got_p8.push_back(inst_pcplus8);
            end
         end
         if (take) m_deliver.push_back(e.addr);
         if (hs) begin
            n.orphan = 1'b0;
            n.rdy    = cyc + 1;
            if (m_stale) begin
               n.addr  = m_stale_addr;
               n.fresh = 1'b0;
               m_stale = 1'b0;
            end else begin
               n.addr      = m_next_addr;
               n.fresh     = 1'b1;
               m_next_addr = m_next_addr + 32'd4;
            end
            imem_q.push_back(n);
            n_hs++;
         end
         if (redirect) begin
            foreach (imem_q[i]) imem_q[i].fresh = 1'b0;
            m_deliver.delete();
            if (imem_req_valid && !hs && !m_stale) begin
               m_stale      = 1'b1;
               m_stale_addr = m_next_addr;
            end
            m_next_addr = {redirect_pc[31:2], 2'b00};
            m_align     = (redirect_pc[1:0] != 2'b00);
         end else begin
            m_align = 1'b0;
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      if (!rsp_hold && imem_q.size() != 0 && imem_q[0].rdy <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = iword(imem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic expect_pop(input string name, input logic [31:0] pc, input logic [31:0] p8);
      int n = 0;
      while (got_pc.size() == 0 && n < 60) begin
         tick();
         n++;
      end
      if (got_pc.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no instruction delivered within %0d cycles, expected pc %h", name, n, pc);
      end else begin
         chk(name, got_pc.pop_front(), pc);
         chk({name, "_p8"}, got_p8.pop_front(), p8);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      got_pc.delete();
      got_p8.delete();
      n_hs = 0;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      tick();
      redirect = 1'b0;
      got_pc.delete();
      got_p8.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1;
      rsp_hold = 1'b0; m_next_addr = 32'h0000_3000; m_stale_addr = '0; m_stale = 1'b0;
      m_align = 1'b0; m_after_rst = 1'b0; prev_stall = 1'b0;
      cyc = 0; errors = 0; checks = 0; n_hs = 0;

      // Reset state and first request right after release.
      tick();
      tick();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_align_err", align_err, 0);
      rst_n = 1'b1;
      tick();
      chk("first_req_valid", imem_req_valid, 1);
      chk("first_req_addr", imem_req_addr, 32'h0000_3000);

      // Streaming fetch.
      expect_pop("t1_pc0", 32'h0000_3000, 32'h0000_3008);
      expect_pop("t1_pc1", 32'h0000_3004, 32'h0000_300C);
      expect_pop("t1_pc2", 32'h0000_3008, 32'h0000_3010);
      expect_pop("t1_pc3", 32'h0000_300C, 32'h0000_3014);

      // Decode stalled: credit limit stops issue after two requests.
      inst_ready = 1'b0;
      do_reset();
      repeat (12) tick();
      chk("t2_hs_count", n_hs, 2);
      chk("t2_req_idle", imem_req_valid, 0);
      chk("t2_inst_pc", inst_pc, 32'h0000_3000);
      inst_ready = 1'b1;
      expect_pop("t2_pc0", 32'h0000_3000, 32'h0000_3008);
      expect_pop("t2_pc1", 32'h0000_3004, 32'h0000_300C);
      expect_pop("t2_pc2", 32'h0000_3008, 32'h0000_3010);

      // imem stalled, redirect while request is held.
      imem_req_ready = 1'b0;
      do_reset();
      tick();
      tick();
      do_redirect(32'h0000_4000);
      tick();
      tick();
      chk("t3_held_valid", imem_req_valid, 1);
      chk("t3_held_addr", imem_req_addr, 32'h0000_3000);
      imem_req_ready = 1'b1;
      expect_pop("t3_pc0", 32'h0000_4000, 32'h0000_4008);

      // Redirect with the output buffer full.
      inst_ready = 1'b0;
      do_reset();
      repeat (6) tick();
      chk("t4a_buffered", inst_valid, 1);
      do_redirect(32'h0000_5008);
      chk("t4a_flushed", inst_valid, 0);
      inst_ready = 1'b1;
      expect_pop("t4a_pc0", 32'h0000_5008, 32'h0000_5010);
      expect_pop("t4a_pc1", 32'h0000_500C, 32'h0000_5014);

      // Redirect with two fetches in flight.
      do_reset();
      rsp_hold = 1'b1;
      repeat (4) tick();
      chk("t4b_inflight", n_hs, 2);
      do_redirect(32'h0000_5008);
      rsp_hold = 1'b0;
      expect_pop("t4b_pc0", 32'h0000_5008, 32'h0000_5010);

      // Misaligned redirect target.
      do_redirect(32'h0000_600A);
      chk("t5_align_pulse", align_err, 1);
      chk("t5_inst_gap", inst_valid, 0);
      tick();
      chk("t5_align_clear", align_err, 0);
      expect_pop("t5_pc0", 32'h0000_6008, 32'h0000_6010);

      // Redirects into a running stream.
      for (int k = 0; k < 3; k++) begin
         do_redirect(32'h0000_7000 + 32'(k) * 32'h104);
         repeat (3 + k) tick();
      end
      expect_pop("t5b_pc0", 32'h0000_7208, 32'h0000_7210);

      // Address wrap, then reset mid-stream with a stale response arriving after release.
      do_redirect(32'hFFFF_FFFC);
      expect_pop("t6_wrap0", 32'hFFFF_FFFC, 32'h0000_0004);
      expect_pop("t6_wrap1", 32'h0000_0000, 32'h0000_0008);
      rsp_hold = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("t6_rst_req_valid", imem_req_valid, 0);
      chk("t6_rst_req_addr", imem_req_addr, 0);
      chk("t6_rst_inst_valid", inst_valid, 0);
      chk("t6_rst_inst_pc", inst_pc, 0);
      chk("t6_rst_inst_data", inst_data, 0);
      chk("t6_rst_pcplus8", inst_pcplus8, 0);
      tick();
      rst_n    = 1'b1;
      rsp_hold = 1'b0;
      got_pc.delete();
      got_p8.delete();
      tick();
      chk("t6_refetch_addr", imem_req_addr, 32'h0000_3000);
      expect_pop("t6_pc0", 32'h0000_3000, 32'h0000_3008);
      expect_pop("t6_pc1", 32'h0000_3004, 32'h0000_300C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
